// File: rtl/quad_enc_gen.sv
// Quadrature transmitter: steps A/B one Gray edge every STEP_DIV cycles until
// the tracked position reaches the commanded target.
module quad_enc_gen #(
    parameter int unsigned STEP_DIV        = 12500,
    parameter int unsigned EDGES_PER_COUNT = 4
) (
    input  logic       pxl_clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    input  logic [5:0] cmd_pos,
    output logic       cmd_ready,
    input  logic       abort,
    output logic       enc_a,
    output logic       enc_b,
    output logic [5:0] cur_pos,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(STEP_DIV - 1);
    localparam logic [1:0]  EDGE_LAST = 2'(EDGES_PER_COUNT - 1);

    state_t      state;
    logic [15:0] div_cnt;
    logic [1:0]  edge_cnt;
    logic [1:0]  phase;
    logic [5:0]  target;
    logic        dir;
    logic        abort_req;

    logic        step;
    logic        count_done;
    logic        stopping;
    logic [1:0]  phase_nx;
    logic [5:0]  pos_nx;

    always_comb begin
        step       = (div_cnt == DIV_LAST);
        count_done = step && (edge_cnt == EDGE_LAST);
        stopping   = abort || abort_req;
        phase_nx   = dir ? phase + 2'd1 : phase - 2'd1;
        pos_nx     = dir ? cur_pos + 6'd1 : cur_pos - 6'd1;
    end

    // Phase index 0..3 maps to AB = 00,10,11,01: A = p1^p0, B = p1.
    always_ff @(posedge pxl_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            div_cnt   <= '0;
            edge_cnt  <= '0;
            phase     <= '0;
            target    <= '0;
            dir       <= 1'b0;
            abort_req <= 1'b0;
            enc_a     <= 1'b0;
            enc_b     <= 1'b0;
            cur_pos   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        target    <= cmd_pos;
                        dir       <= (cmd_pos > cur_pos);
                        div_cnt   <= '0;
                        edge_cnt  <= '0;
                        abort_req <= 1'b0;
                        cmd_ready <= 1'b0;
                        if (cmd_pos == cur_pos) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort)
                        abort_req <= 1'b1;
                    if (step) begin
                        div_cnt <= '0;
                        phase   <= phase_nx;
                        enc_a   <= phase_nx[1] ^ phase_nx[0];
                        enc_b   <= phase_nx[1];
                        if (count_done) begin
                            edge_cnt <= '0;
                            cur_pos  <= pos_nx;
                            if ((pos_nx == target) || stopping) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            edge_cnt <= edge_cnt + 2'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 16'd1;
                        // Already resting on a count boundary: nothing left to finish.
                        if (stopping && (edge_cnt == '0)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    abort_req <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
